// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux scan controller: channel geometry, FSM states,
// and the enabled-channel priority search.
package mux_scan_pkg;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned SEL_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } scan_state_e;

  // Returns {found, index} of the lowest enabled channel at or above 'from'.
  function automatic logic [SEL_W:0] find_ch(input logic [NUM_CH-1:0] mask,
                                             input logic [SEL_W:0]    from);
    logic [SEL_W:0] r;
    r = '0;
    for (int unsigned i = NUM_CH; i > 0; i--) begin
      if ((i - 1) >= 32'(from) && mask[i-1]) begin
        r = {1'b1, SEL_W'(i - 1)};
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_scan_dwell_cnt.sv
// Per-channel settle countdown; a load of 0 is treated as 1 so every channel
// dwells at least one cycle.
module mux_scan_dwell_cnt #(
  parameter int unsigned DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DWELL_W-1:0] load_val,
  input  logic               dec,
  output logic               last
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= (load_val == '0) ? DWELL_W'(1) : load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  assign last = (cnt_q == DWELL_W'(1));

endmodule

// File: rtl/mux_scan_ctrl.sv
// Scans the enabled channels of a downstream 8:1 mux and assembles a sample frame.
// Optional MUX_SCAN_PARITY_EN adds the registered odd-parity output frame_par.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int unsigned DWELL_W = 4,
  parameter int unsigned NUM_CH  = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         ch_mask,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               y,
  output logic               s0,
  output logic               s1,
  output logic               s2,
  output logic [7:0]         frame,
  output logic               frame_valid,
  input  logic               frame_ready,
`ifdef MUX_SCAN_PARITY_EN
  output logic               frame_par,
`endif
  output logic               busy
);

  scan_state_e        state_q, state_d;
  logic [7:0]         mask_q, mask_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [7:0]         acc_q, acc_d;
  logic [7:0]         frame_q, frame_d;
  logic [7:0]         cap;
  logic [SEL_W:0]     first_ch, next_ch;
  logic               cnt_load, cnt_dec, cnt_last;
  logic [DWELL_W-1:0] cnt_val;

  mux_scan_dwell_cnt #(.DWELL_W(DWELL_W)) u_dwell_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .last     (cnt_last)
  );

  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    dwell_d  = dwell_q;
    sel_d    = sel_q;
    acc_d    = acc_q;
    frame_d  = frame_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = dwell_q;
    first_ch = find_ch(ch_mask, '0);
    next_ch  = find_ch(mask_q, {1'b0, sel_q} + 1'b1);
    cap      = acc_q;
    cap[sel_q] = y;
    unique case (state_q)
      ST_IDLE: begin
        if (start && ch_mask != '0) begin
          mask_d   = ch_mask;
          dwell_d  = dwell;
          acc_d    = '0;
          sel_d    = first_ch[SEL_W-1:0];
          cnt_load = 1'b1;
          cnt_val  = dwell;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_last) begin
          acc_d = cap;
          // Reload and move straight to the next enabled channel: no gap cycle.
          if (next_ch[SEL_W]) begin
            sel_d    = next_ch[SEL_W-1:0];
            cnt_load = 1'b1;
          end else begin
            frame_d = cap;
            state_d = ST_HOLD;
          end
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (frame_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      dwell_q <= '0;
      sel_q   <= '0;
      acc_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      dwell_q <= dwell_d;
      sel_q   <= sel_d;
      acc_q   <= acc_d;
      frame_q <= frame_d;
    end
  end

`ifdef MUX_SCAN_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_par <= 1'b1;
    end else begin
      frame_par <= ~^frame_d;
    end
  end
`endif

  // Select is forced to 0 in IDLE; in HOLD sel_q still names the last sampled channel.
  assign {s2, s1, s0} = (state_q == ST_IDLE) ? 3'b000 : sel_q;
  assign frame        = frame_q;
  assign frame_valid  = (state_q == ST_HOLD);
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: y is modelled as an 8:1 mux over a pattern byte.
module tb_mux_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] ch_mask = '0;
  logic [3:0] dwell = '0;
  logic       y;
  logic       s0, s1, s2;
  logic [7:0] frame;
  logic       frame_valid;
  logic       frame_ready = 1'b0;
  logic       busy;
`ifdef MUX_SCAN_PARITY_EN
  logic       frame_par;
`endif

  logic [7:0] pat = '0;
  logic [2:0] sel_log[$];
  int         n_total = 0;
  int         n_bad = 0;
  int         lat;

  always #5 clk = ~clk;

  assign y = pat[{s2, s1, s0}];

  mux_scan_ctrl #(.DWELL_W(4), .NUM_CH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .ch_mask     (ch_mask),
    .dwell       (dwell),
    .y           (y),
    .s0          (s0),
    .s1          (s1),
    .s2          (s2),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
`ifdef MUX_SCAN_PARITY_EN
    .frame_par   (frame_par),
`endif
    .busy        (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issues start, scrambles mask/dwell while busy, logs selects until frame_valid.
  task automatic run_scan(input logic [7:0] m, input logic [3:0] d, input logic [7:0] p,
                          output int l);
    pat = p;
    sel_log.delete();
    @(negedge clk);
    ch_mask = m; dwell = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; ch_mask = ~m; dwell = 4'd0;
    l = 1;
    while (!frame_valid && l < 200) begin
      sel_log.push_back({s2, s1, s0});
      @(posedge clk); #1;
      l++;
    end
    chk("fv_up", {31'd0, frame_valid}, 32'd1);
  endtask

  task automatic release_frame();
    @(negedge clk);
    frame_ready = 1'b1;
    @(posedge clk); #1;
    frame_ready = 1'b0;
  endtask

  initial begin
    logic [2:0] exp2[6];
    exp2 = '{3'd1, 3'd1, 3'd1, 3'd7, 3'd7, 3'd7};

    // Reset state
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fv", {31'd0, frame_valid}, 32'd0);
    chk("rst_frame", {24'd0, frame}, 32'h00);
    chk("rst_sel", {29'd0, s2, s1, s0}, 32'd0);
`ifdef MUX_SCAN_PARITY_EN
    chk("rst_par", {31'd0, frame_par}, 32'd1);
`endif

    // Full mask, dwell 1, pattern A5
    run_scan(8'hFF, 4'd1, 8'hA5, lat);
    chk("t1_lat", lat, 9);
    chk("t1_frame", {24'd0, frame}, 32'hA5);
    chk("t1_nsel", sel_log.size(), 8);
    for (int i = 0; i < sel_log.size() && i < 8; i++)
      chk($sformatf("t1_sel%0d", i), {29'd0, sel_log[i]}, i);
    chk("t1_hold_sel", {29'd0, s2, s1, s0}, 32'd7);
`ifdef MUX_SCAN_PARITY_EN
    chk("t1_par", {31'd0, frame_par}, 32'd1);
`endif
    release_frame();
    chk("t1_idle", {30'd0, busy, frame_valid}, 32'd0);
    chk("t1_keep", {24'd0, frame}, 32'hA5);
    chk("t1_idle_sel", {29'd0, s2, s1, s0}, 32'd0);

    // Sparse mask with dwell 3
    run_scan(8'b1000_0010, 4'd3, 8'hFF, lat);
    chk("t2_lat", lat, 7);
    chk("t2_frame", {24'd0, frame}, 32'h82);
    chk("t2_nsel", sel_log.size(), 6);
    for (int i = 0; i < sel_log.size() && i < 6; i++)
      chk($sformatf("t2_sel%0d", i), {29'd0, sel_log[i]}, {29'd0, exp2[i]});

    // Held in HOLD: ready low 5 cycles, a start in HOLD is ignored
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = (i == 2);
      ch_mask = 8'hFF;
      @(posedge clk); #1;
      start = 1'b0;
      chk($sformatf("t4_hold%0d", i), {23'd0, frame_valid, frame}, 32'h182);
    end
    chk("t4_hold_sel", {29'd0, s2, s1, s0}, 32'd7);
    release_frame();
    chk("t4_rel", {30'd0, busy, frame_valid}, 32'd0);
    chk("t4_keep", {24'd0, frame}, 32'h82);
    @(posedge clk); #1;
    chk("t4_stay_idle", {31'd0, busy}, 32'd0);

    // Dwell 0 behaves as dwell 1
    run_scan(8'h01, 4'd0, 8'hFF, lat);
    chk("t3_lat", lat, 2);
    chk("t3_frame", {24'd0, frame}, 32'h01);
`ifdef MUX_SCAN_PARITY_EN
    chk("t3_par", {31'd0, frame_par}, 32'd0);
`endif
    release_frame();

    // Start with empty mask is ignored
    @(negedge clk);
    ch_mask = 8'h00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t3_zero_mask", {31'd0, busy}, 32'd0);

    // Reset during 4th channel, start coincident with reset
    pat = 8'hFF;
    @(negedge clk);
    ch_mask = 8'hFF; dwell = 4'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("t5_ch3", {29'd0, s2, s1, s0}, 32'd3);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    chk("t5_rst", {19'd0, busy, frame_valid, s2, s1, s0, frame}, 32'd0);
    @(posedge clk); #1;
    chk("t5_rst_start", {31'd0, busy}, 32'd0);
    run_scan(8'hFF, 4'd2, 8'h3C, lat);
    chk("t5_lat", lat, 17);
    chk("t5_frame", {24'd0, frame}, 32'h3C);
    release_frame();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: DWELL_W, 4, width of dwell count.
REQ-002 Parameter: NUM_CH, 8, channels scanned (fixed at 8; drives 3 select lines).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: start  input  1  one-cycle request to begin one scan frame.
REQ-006 Port: ch_mask  input  8  channel enable; bit k enables channel k.
REQ-007 Port: dwell  input  DWELL_W  settle cycles per channel before sampling.
REQ-008 Port: y  input  1  selected bit returned by the downstream 8:1 mux.
REQ-009 Port: s0, s1, s2  output  1 each  channel select to the mux (s2 MSB).
REQ-010 Port: frame  output  8  assembled sample frame, bit k = sample of channel k.
REQ-011 Port: frame_valid  output  1  frame holds a completed scan.
REQ-012 Port: frame_ready  input  1  consumer accepts frame.
REQ-013 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states SHALL be IDLE, SETTLE, HOLD; encoding taken from the shared package.
REQ-015 In IDLE, start=1 with ch_mask!=0 SHALL latch ch_mask and dwell, clear the accumulator, select the lowest enabled channel, load the counter and enter SETTLE next cycle.
REQ-016 start with ch_mask==0 SHALL be ignored (stay IDLE); start outside IDLE SHALL be ignored.
REQ-017 Effective dwell SHALL be max(dwell,1); each enabled channel SHALL hold its select for exactly that many cycles in SETTLE.
REQ-018 On the last SETTLE cycle of a channel, y SHALL be captured into accumulator bit [channel] at that clock edge.
REQ-019 After capture, select SHALL advance to the next higher enabled channel with no gap cycle; disabled channels are skipped in zero cycles.
REQ-020 When no higher enabled channel remains, the FSM SHALL enter HOLD, load frame from the accumulator and assert frame_valid in the same cycle.
REQ-021 Disabled channel bits in frame SHALL be 0.
REQ-022 Latency start -> frame_valid SHALL be popcount(mask)*max(dwell,1)+1 cycles.
REQ-023 In HOLD, frame and frame_valid SHALL stay stable until frame_valid&frame_ready; the following cycle SHALL be IDLE with frame_valid=0; frame retains its value.
REQ-024 s2..s0 SHALL be 3'b000 in IDLE and hold the last sampled channel in HOLD.
REQ-025 Changes to ch_mask/dwell while busy SHALL have no effect on the current frame.

Reset
REQ-026 rst=1 at any edge, including mid-scan or in HOLD, SHALL force IDLE, and outputs s0..s2=0, frame=0, frame_valid=0, busy=0 on the next cycle; accumulator and counter cleared.
REQ-027 start asserted in the same cycle as rst SHALL be ignored.

Configuration
REQ-028 Macro MUX_SCAN_PARITY_EN, when defined, SHALL add output frame_par (1 bit, odd parity over the 8 frame bits: XOR of frame bits inverted), registered with frame, reset to 1 (odd parity of 0), stable under the same rules as frame.
REQ-029 Without MUX_SCAN_PARITY_EN, port frame_par and its logic SHALL not exist; all other behaviour is identical.

Structure
REQ-030 Package mux_scan_pkg SHALL hold NUM_CH=8, SEL_W=3, the state enumeration typedef, and a next-enabled-channel function (priority search above current index).
REQ-031 Per-channel dwell countdown SHALL be a sub-module mux_scan_dwell_cnt (load, decrement, last-cycle flag).

Verification
REQ-032 mask=8'hFF, dwell=1, y driven = i-pattern 8'hA5 indexed by {s2,s1,s0} -> frame=8'hA5, frame_valid at cycle 9 after start, selects step 0..7 once per cycle.
REQ-033 mask=8'b1000_0010, dwell=3, pattern 8'hFF -> selects 1 for 3 cycles then 7 for 3 cycles, frame=8'h82, valid at cycle 7.
REQ-034 dwell=0, mask=8'h01, y=1 -> treated as dwell 1, frame=8'h01 valid at cycle 2; start with mask=0 -> busy stays 0.
REQ-035 frame_ready held low 5 cycles in HOLD, then pulsed -> frame/frame_valid stable throughout, IDLE next cycle; second start in HOLD ignored.
REQ-036 rst pulsed during 4th channel of an FF scan -> next cycle all outputs 0, busy=0; new start produces correct full frame.
REQ-037 With MUX_SCAN_PARITY_EN, frame=8'hA5 -> frame_par=1; frame=8'h01 -> frame_par=0.
